// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared state encoding and default widths for the ping-pong buffer controller
package pingpong_pkg;
  typedef enum logic {FILL, FULL} state_t;
  localparam int PPC_DATA_W = 12;
  localparam int PPC_ADDR_W = 10;
endpackage

// File: rtl/ppc_sat_cnt.sv
// ppc_sat_cnt: 16-bit event counter saturating at 16'hFFFF
module ppc_sat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: ping-pong group buffer sequencer; PPC_STATS_EN adds saturating underrun/overrun counters
module pingpong_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_W = PPC_DATA_W,
  parameter int ADDR_W = PPC_ADDR_W,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W:0]   wr_fill,
  input  logic              rd_swap,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_sel,
  output logic              rd_primed,
  output logic [ADDR_W-1:0] mem_wadr,
  output logic [DATA_W-1:0] mem_wdat,
  output logic              m0_we,
  output logic              m1_we,
  output logic [ADDR_W-1:0] mem_radr,
  output logic              m0_re,
  output logic              m1_re,
  input  logic [DATA_W-1:0] m0_q,
  input  logic [DATA_W-1:0] m1_q,
  output logic              underrun,
  output logic              overrun
`ifdef PPC_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       overrun_cnt
`endif
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W:0] fill_n;
  logic sel_n, primed_n, dropped, dropped_n, under_n, over_n;
  logic accept, reach, swap_ok, drop;
  logic sel_q, rd_vld;
  logic [DATA_W-1:0] hold;
  assign wr_ready = state == FILL;
  assign accept   = wr_valid & wr_ready;
  assign reach    = accept && wr_fill == LAST;
  assign swap_ok  = rd_swap & (state == FULL | reach);
  assign drop     = wr_valid & ~wr_ready;
  assign mem_wadr = wr_fill[ADDR_W-1:0];
  assign mem_wdat = wr_data;
  assign m0_we    = accept & rd_sel;
  assign m1_we    = accept & ~rd_sel;
  assign mem_radr = rd_addr;
  assign m0_re    = rd_en & ~rd_sel;
  assign m1_re    = rd_en & rd_sel;
  assign rd_data  = rd_vld ? (sel_q ? m1_q : m0_q) : hold;
  always_comb begin
    state_n   = swap_ok ? FILL : (reach ? FULL : state);
    fill_n    = swap_ok ? '0 : wr_fill + {{ADDR_W{1'b0}}, accept};
    sel_n     = rd_sel ^ swap_ok;
    primed_n  = rd_primed | swap_ok;
    dropped_n = ~swap_ok & (dropped | drop);
    under_n   = rd_swap & ~swap_ok;
    over_n    = drop & ~dropped;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_fill   <= '0;
      rd_sel    <= 1'b1;
      rd_primed <= 1'b0;
      dropped   <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      sel_q     <= 1'b0;
      rd_vld    <= 1'b0;
      hold      <= '0;
    end else begin
      state     <= state_n;
      wr_fill   <= fill_n;
      rd_sel    <= sel_n;
      rd_primed <= primed_n;
      dropped   <= dropped_n;
      underrun  <= under_n;
      overrun   <= over_n;
      sel_q     <= rd_en ? rd_sel : sel_q;
      rd_vld    <= rd_en;
      hold      <= rd_data;
    end
  end
`ifdef PPC_STATS_EN
  ppc_sat_cnt u_under_cnt (.clk(clk), .reset(reset), .inc(under_n), .cnt(underrun_cnt));
  ppc_sat_cnt u_over_cnt  (.clk(clk), .reset(reset), .inc(over_n),  .cnt(overrun_cnt));
`endif
endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl: directed scenarios plus randomized run against a behavioural ping-pong model
module tb_pingpong_ctrl;
  localparam int DW = 12;
  localparam int AW = 10;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic wr_valid = 0, rd_swap = 0, rd_en = 0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic wr_ready, rd_sel, rd_primed, m0_we, m1_we, m0_re, m1_re, underrun, overrun;
  logic [AW:0] wr_fill;
  logic [DW-1:0] rd_data, mem_wdat;
  logic [DW-1:0] m0_q = '0, m1_q = '0;
  logic [AW-1:0] mem_wadr, mem_radr;
  logic [DW-1:0] ram0 [1024];
  logic [DW-1:0] ram1 [1024];
  logic [DW-1:0] sb [2][1024];
`ifdef PPC_STATS_EN
  logic [15:0] underrun_cnt, overrun_cnt;
`endif
  int n_cmp = 0, n_err = 0;

  pingpong_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_fill(wr_fill), .rd_swap(rd_swap), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_sel(rd_sel), .rd_primed(rd_primed), .mem_wadr(mem_wadr), .mem_wdat(mem_wdat),
    .m0_we(m0_we), .m1_we(m1_we), .mem_radr(mem_radr), .m0_re(m0_re), .m1_re(m1_re),
    .m0_q(m0_q), .m1_q(m1_q), .underrun(underrun), .overrun(overrun)
`ifdef PPC_STATS_EN
    , .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m0_we) ram0[mem_wadr] <= mem_wdat;
    if (m1_we) ram1[mem_wadr] <= mem_wdat;
    if (m0_re) m0_q <= ram0[mem_radr];
    if (m1_re) m1_q <= ram1[mem_radr];
  end

  task automatic do_reset();
    reset = 1; wr_valid = 0; rd_swap = 0; rd_en = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    wr_valid = 1; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (wr_fill !== 0) begin n_err++; $display("FAIL rst_fill got %0d want 0", wr_fill); end
    n_cmp++; if (rd_sel !== 1'b1) begin n_err++; $display("FAIL rst_sel got %b want 1", rd_sel); end
    n_cmp++; if (rd_primed !== 1'b0) begin n_err++; $display("FAIL rst_primed got %b want 0", rd_primed); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", wr_ready); end
    n_cmp++; if ({underrun, overrun} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {underrun, overrun}); end
    n_cmp++; if ({m0_we, m1_we, m0_re, m1_re} !== 4'b0) begin n_err++; $display("FAIL rst_en got %b want 0000", {m0_we, m1_we, m0_re, m1_re}); end
`ifdef PPC_STATS_EN
    n_cmp++; if ({underrun_cnt, overrun_cnt} !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %h want 0", {underrun_cnt, overrun_cnt}); end
`endif
  endtask

  task automatic test_fill_swap();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = DW'($urandom); wr_valid = 1; wr_data = d; #1;
      n_cmp++; if ({m0_we, m1_we} !== 2'b10) begin n_err++; $display("FAIL fill_we[%0d] got %b want 10", i, {m0_we, m1_we}); end
      n_cmp++; if (mem_wadr !== AW'(i) || mem_wdat !== d) begin n_err++; $display("FAIL fill_adr[%0d] got %0d/%h want %0d/%h", i, mem_wadr, mem_wdat, i, d); end
      @(posedge clk); #1;
    end
    wr_valid = 0;
    n_cmp++; if (wr_fill !== (AW+1)'(DEPTH) || wr_ready !== 1'b0) begin n_err++; $display("FAIL full_state got %0d/%b want %0d/0", wr_fill, wr_ready, DEPTH); end
    rd_swap = 1; @(posedge clk); #1; rd_swap = 0;
    n_cmp++; if ({rd_sel, rd_primed, wr_ready} !== 3'b011 || wr_fill !== 0) begin n_err++; $display("FAIL swap got sel%b pr%b rdy%b fill%0d want 0 1 1 0", rd_sel, rd_primed, wr_ready, wr_fill); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL swap_under got %b want 0", underrun); end
  endtask

  task automatic test_underrun();
    do_reset();
    wr_word(12'h001); wr_word(12'h002);
    rd_swap = 1; @(posedge clk); #1; rd_swap = 0;
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL under_pulse got %b want 1", underrun); end
    n_cmp++; if (rd_sel !== 1'b1 || wr_fill !== 2 || rd_primed !== 1'b0) begin n_err++; $display("FAIL under_hold got sel%b fill%0d pr%b want 1 2 0", rd_sel, wr_fill, rd_primed); end
    @(posedge clk); #1;
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL under_width got %b want 0", underrun); end
  endtask

  task automatic test_swap_on_last();
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) wr_word(DW'(i));
    wr_valid = 1; wr_data = 12'h7E7; rd_swap = 1; #1;
    n_cmp++; if (m0_we !== 1'b1 || mem_wadr !== AW'(DEPTH - 1) || mem_wdat !== 12'h7E7) begin n_err++; $display("FAIL last_wr got %b/%0d/%h want 1/%0d/7e7", m0_we, mem_wadr, mem_wdat, DEPTH - 1); end
    @(posedge clk); #1; wr_valid = 0; rd_swap = 0;
    n_cmp++; if ({rd_sel, rd_primed, wr_ready, underrun} !== 4'b0110 || wr_fill !== 0) begin n_err++; $display("FAIL last_swap got sel%b pr%b rdy%b un%b fill%0d want 0 1 1 0 0", rd_sel, rd_primed, wr_ready, underrun, wr_fill); end
    n_cmp++; if (ram0[DEPTH-1] !== 12'h7E7) begin n_err++; $display("FAIL last_ram got %h want 7e7", ram0[DEPTH-1]); end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr_word(DW'(i + 16));
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = 12'hFFF; #1;
      n_cmp++; if ({m0_we, m1_we, wr_ready} !== 3'b000) begin n_err++; $display("FAIL ovr_we[%0d] got %b want 000", i, {m0_we, m1_we, wr_ready}); end
      @(posedge clk); #1;
      if (i == 0) begin
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_first got %b want 1", overrun); end
      end
      pulses += int'(overrun);
    end
    wr_valid = 0; @(posedge clk); #1;
    pulses += int'(overrun);
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL ovr_count got %0d want 1", pulses); end
    n_cmp++; if (wr_fill !== (AW+1)'(DEPTH)) begin n_err++; $display("FAIL ovr_fill got %0d want %0d", wr_fill, DEPTH); end
`ifdef PPC_STATS_EN
    n_cmp++; if (overrun_cnt !== 16'd1) begin n_err++; $display("FAIL ovr_cnt got %0d want 1", overrun_cnt); end
`endif
  endtask

  task automatic test_read_swap();
    do_reset();
    ram1[0] = 12'h0A5;
    wr_word(12'h15A);
    for (int i = 1; i < DEPTH; i++) wr_word(DW'(i));
    rd_swap = 1; rd_en = 1; rd_addr = '0; #1;
    n_cmp++; if ({m0_re, m1_re} !== 2'b01) begin n_err++; $display("FAIL rd_pre_re got %b want 01", {m0_re, m1_re}); end
    @(posedge clk); #1; rd_swap = 0; rd_en = 0;
    n_cmp++; if (rd_data !== 12'h0A5 || rd_sel !== 1'b0) begin n_err++; $display("FAIL rd_pre got %h sel%b want 0a5 sel0", rd_data, rd_sel); end
    rd_en = 1; #1;
    n_cmp++; if ({m0_re, m1_re} !== 2'b10) begin n_err++; $display("FAIL rd_post_re got %b want 10", {m0_re, m1_re}); end
    @(posedge clk); #1; rd_en = 0;
    n_cmp++; if (rd_data !== 12'h15A) begin n_err++; $display("FAIL rd_post got %h want 15a", rd_data); end
    @(posedge clk); #1;
    n_cmp++; if (rd_data !== 12'h15A) begin n_err++; $display("FAIL rd_hold got %h want 15a", rd_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_word(12'h111); wr_word(12'h222);
    rd_swap = 1; @(posedge clk); #1; rd_swap = 0;
    wr_word(12'h333);
    n_cmp++; if (wr_fill !== 3) begin n_err++; $display("FAIL mid_pre got %0d want 3", wr_fill); end
    reset = 1; @(posedge clk); #1; reset = 0;
    n_cmp++; if (wr_fill !== 0 || {rd_sel, rd_primed, wr_ready} !== 3'b101) begin n_err++; $display("FAIL mid_rst got fill%0d sel%b pr%b rdy%b want 0 1 0 1", wr_fill, rd_sel, rd_primed, wr_ready); end
`ifdef PPC_STATS_EN
    n_cmp++; if ({underrun_cnt, overrun_cnt} !== 32'd0) begin n_err++; $display("FAIL mid_cnt got %h want 0", {underrun_cnt, overrun_cnt}); end
`endif
  endtask

  task automatic test_random();
    int m_fill = 0, m_ucnt = 0, m_ocnt = 0;
    bit m_wb = 0, m_full = 0, m_primed = 0, m_dropped = 0, e_under = 0, e_over = 0, rd_known = 0;
    bit wv, sw, re, acc, full_now;
    logic [DW-1:0] wd, e_rd = '0, rdv;
    logic [AW-1:0] ra;
    do_reset();
    for (int i = 0; i < 1024; i++) begin sb[0][i] = ram0[i]; sb[1][i] = ram1[i]; end
    for (int c = 0; c < 400; c++) begin
      wv = $urandom_range(0, 99) < 60; sw = $urandom_range(0, 99) < 10; re = $urandom_range(0, 1) == 1;
      wd = DW'($urandom); ra = AW'($urandom_range(0, DEPTH - 1));
      wr_valid = wv; wr_data = wd; rd_swap = sw; rd_en = re; rd_addr = ra; #1;
      acc = wv && !m_full;
      n_cmp++; if ({m0_we, m1_we} !== {acc && !m_wb, acc && m_wb}) begin n_err++; $display("FAIL rnd_we c%0d got %b want %b", c, {m0_we, m1_we}, {acc && !m_wb, acc && m_wb}); end
      if (acc) begin
        n_cmp++; if (mem_wadr !== AW'(m_fill) || mem_wdat !== wd) begin n_err++; $display("FAIL rnd_wadr c%0d got %0d/%h want %0d/%h", c, mem_wadr, mem_wdat, m_fill, wd); end
      end
      n_cmp++; if ({m0_re, m1_re} !== {re && m_wb, re && !m_wb}) begin n_err++; $display("FAIL rnd_re c%0d got %b want %b", c, {m0_re, m1_re}, {re && m_wb, re && !m_wb}); end
      rdv = sb[!m_wb][ra];
      if (acc) sb[m_wb][m_fill] = wd;
      full_now = m_full || (acc && m_fill + 1 == DEPTH);
      e_over = wv && m_full && !m_dropped;
      m_dropped = m_dropped || (wv && m_full);
      e_under = sw && !full_now;
      m_ucnt += int'(e_under); m_ocnt += int'(e_over);
      if (sw && full_now) begin
        m_wb = !m_wb; m_fill = 0; m_full = 0; m_primed = 1; m_dropped = 0;
      end else begin
        m_fill += int'(acc); m_full = full_now;
      end
      if (re) begin e_rd = rdv; rd_known = 1; end
      @(posedge clk); #1;
      n_cmp++; if (wr_fill !== (AW+1)'(m_fill) || wr_ready !== !m_full) begin n_err++; $display("FAIL rnd_fill c%0d got %0d/%b want %0d/%b", c, wr_fill, wr_ready, m_fill, !m_full); end
      n_cmp++; if (rd_sel !== !m_wb || rd_primed !== m_primed) begin n_err++; $display("FAIL rnd_sel c%0d got %b/%b want %b/%b", c, rd_sel, rd_primed, !m_wb, m_primed); end
      n_cmp++; if ({underrun, overrun} !== {e_under, e_over}) begin n_err++; $display("FAIL rnd_flags c%0d got %b want %b", c, {underrun, overrun}, {e_under, e_over}); end
      if (rd_known) begin
        n_cmp++; if (rd_data !== e_rd) begin n_err++; $display("FAIL rnd_rd c%0d got %h want %h", c, rd_data, e_rd); end
      end
`ifdef PPC_STATS_EN
      n_cmp++; if (underrun_cnt !== 16'(m_ucnt) || overrun_cnt !== 16'(m_ocnt)) begin n_err++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, underrun_cnt, overrun_cnt, m_ucnt, m_ocnt); end
`endif
    end
    wr_valid = 0; rd_swap = 0; rd_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ram0[i] = '0; ram1[i] = '0; end
    test_reset();
    test_fill_swap();
    test_underrun();
    test_swap_on_last();
    test_overrun();
    test_read_swap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
